// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Purpose : shared constants for the memory arbiter slice: default requester
//           count, address/data widths, top of the memory map, FSM state
//           encoding and a helper for sizing requester index fields.
// Contents: NREQ, AW, DW, MEM_TOP, ST_IDLE, ST_ACCESS, idx_width()
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    // Defaults used by the top-level parameters.
    localparam int          NREQ    = 3;
    localparam int          AW      = 16;
    localparam int          DW      = 16;
    localparam logic [15:0] MEM_TOP = 16'h07FF;

    // FSM state encoding. Kept as plain constants so that older tools and
    // netlist viewers see a simple one-bit register.
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    // Width of a field that holds a requester index. A single requester
    // still needs a one-bit field so that vectors never collapse to zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purpose : round-robin winner selection. Scans the request vector starting
//           one position after the previous owner, wrapping modulo NREQ, and
//           returns the first requester found.
// Ports   : req_i        - request vector, one bit per requester
//           last_owner_i - index of the requester that owned the port last
//           winner_o     - one-hot winner (all zero when nothing requested)
//           valid_o      - at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ = 3,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_owner_i,
    output logic [NREQ-1:0] winner_o,
    output logic            valid_o
);
    import mem_arbiter_pkg::*;

    // Scan position for each of the NREQ candidates, in priority order.
    // scan_idx[0] is the requester right after the last owner.
    logic [IW-1:0] scan_idx [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_scan
            if (gi == 0) begin : g_first
                assign scan_idx[gi] = (last_owner_i == IW'(NREQ - 1)) ? '0
                                    : last_owner_i + IW'(1);
            end else begin : g_next
                assign scan_idx[gi] = (scan_idx[gi-1] == IW'(NREQ - 1)) ? '0
                                    : scan_idx[gi-1] + IW'(1);
            end
        end
    endgenerate

    always_comb begin
        logic found;
        winner_o = '0;
        found    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_i[scan_idx[k]]) begin
                winner_o[scan_idx[k]] = 1'b1;
                found                 = 1'b1;
            end
        end
    end

    assign valid_o = |req_i;

endmodule : rr_pick

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Purpose : shares one single-port memory between NREQ requesters. An idle
//           cycle arbitrates round-robin; the winner then owns the port for
//           one access per cycle, extended cycle by cycle while it holds both
//           lock and req. Every ownership ends with a dead IDLE cycle so a
//           requester can drop req after seeing its grant.
//           Words are DW bits wide at byte addresses; a word occupies addr and
//           addr+1, so the last legal word address is MEM_TOP-1.
// Ports   : clock        - sole clock, rising edge
//           nrst         - synchronous active-low reset
//           req/wr/lock  - per-requester request, write select, burst hold
//           addr/wdata   - packed per-requester address / write data
//           gnt          - registered one-hot grant (high during the access)
//           done/err     - one-cycle pulses the cycle after each access
//           rdata        - registered read data, shared, holds between pulses
//           mem_address/mem_wr_en/mem_data_in/mem_data_out - memory port,
//                          memory read is combinational
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int              NREQ    = mem_arbiter_pkg::NREQ,
    parameter int              AW      = mem_arbiter_pkg::AW,
    parameter int              DW      = mem_arbiter_pkg::DW,
    parameter logic [AW-1:0]   MEM_TOP = mem_arbiter_pkg::MEM_TOP
) (
    input  logic                 clock,
    input  logic                 nrst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      wr,
    input  logic [NREQ-1:0]      lock,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*DW-1:0]   wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [NREQ-1:0]      err,
    output logic [DW-1:0]        rdata,
    output logic [AW-1:0]        mem_address,
    output logic                 mem_wr_en,
    output logic [DW-1:0]        mem_data_in,
    input  logic [DW-1:0]        mem_data_out
);
    import mem_arbiter_pkg::*;

    localparam int            IW        = idx_width(NREQ);
    // Highest address whose second byte (addr+1) is still inside the memory.
    localparam logic [AW-1:0] LAST_WORD = MEM_TOP - AW'(1);

    // ------------------------------------------------------------------
    // Unpack the per-requester buses
    // ------------------------------------------------------------------
    logic [AW-1:0] addr_arr  [NREQ];
    logic [DW-1:0] wdata_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = addr[gi*AW +: AW];
            assign wdata_arr[gi] = wdata[gi*DW +: DW];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]      state_q,      state_d;
    logic [IW-1:0]   owner_q,      owner_d;
    logic [IW-1:0]   last_owner_q, last_owner_d;
    logic [NREQ-1:0] gnt_q,        gnt_d;
    logic [NREQ-1:0] done_q,       done_d;
    logic [NREQ-1:0] err_q,        err_d;
    logic [DW-1:0]   rdata_q,      rdata_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NREQ-1:0] win_oh;
    logic            win_valid;
    logic [IW-1:0]   win_idx;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req_i        (req),
        .last_owner_i (last_owner_q),
        .winner_o     (win_oh),
        .valid_o      (win_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_oh[i]) begin
                win_idx = IW'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Owner-side datapath
    // ------------------------------------------------------------------
    logic            in_access;
    logic [AW-1:0]   cur_addr;
    logic [DW-1:0]   cur_wdata;
    logic            cur_wr;
    logic            range_err;
    logic            hold_burst;
    logic [NREQ-1:0] owner_oh;

    assign in_access  = (state_q == ST_ACCESS);
    assign cur_addr   = addr_arr[owner_q];
    assign cur_wdata  = wdata_arr[owner_q];
    assign cur_wr     = wr[owner_q];
    assign range_err  = in_access && (cur_addr > LAST_WORD);
    assign hold_burst = lock[owner_q] && req[owner_q];
    assign owner_oh   = NREQ'(1) << owner_q;

    // Memory port. Reset gates the write enable combinationally so an access
    // caught by reset never lands in memory.
    assign mem_address = in_access ? cur_addr  : '0;
    assign mem_data_in = in_access ? cur_wdata : '0;
    assign mem_wr_en   = in_access && cur_wr && !range_err && nrst;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        gnt_d        = gnt_q;
        done_d       = '0;
        err_d        = '0;
        rdata_d      = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    state_d = ST_ACCESS;
                    owner_d = win_idx;
                    gnt_d   = win_oh;
                end
            end

            ST_ACCESS: begin
                // Completion of the access performed this cycle. A write
                // also captures the word that was at the address before it.
                done_d  = owner_oh;
                err_d   = range_err ? owner_oh : '0;
                rdata_d = range_err ? '0 : mem_data_out;

                if (!hold_burst) begin
                    state_d      = ST_IDLE;
                    gnt_d        = '0;
                    last_owner_d = owner_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!nrst) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            // Pointing at the last requester makes requester 0 the first
            // candidate after reset.
            last_owner_q <= IW'(NREQ - 1);
            gnt_q        <= '0;
            done_q       <= '0;
            err_q        <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign err   = err_q;
    assign rdata = rdata_q;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed scenarios followed by randomized traffic. A byte-array memory sits
// on the DUT memory port; a second byte array plus a transaction-level model
// (round-robin order, dead cycle, done/err/rdata timing) predicts every output.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 16;
    localparam int DW   = 16;

    logic              clock;
    logic              nrst;
    logic [NREQ-1:0]   req, wr, lock;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]   gnt, done, err;
    logic [DW-1:0]     rdata;
    logic [AW-1:0]     mem_address;
    logic              mem_wr_en;
    logic [DW-1:0]     mem_data_in, mem_data_out;

    logic [7:0] mem     [0:2047];
    logic [7:0] ref_mem [0:2047];

    int         checks   = 0;
    int         failures = 0;
    logic [2:0] m_gnt;
    logic [15:0] m_rdata;
    int         m_last;
    logic       m_valid;
    logic       bad_we_seen = 1'b0;

    mem_arbiter #(
        .NREQ    (NREQ),
        .AW      (AW),
        .DW      (DW),
        .MEM_TOP (16'h07FF)
    ) dut (
        .clock        (clock),
        .nrst         (nrst),
        .req          (req),
        .wr           (wr),
        .lock         (lock),
        .addr         (addr),
        .wdata        (wdata),
        .gnt          (gnt),
        .done         (done),
        .err          (err),
        .rdata        (rdata),
        .mem_address  (mem_address),
        .mem_wr_en    (mem_wr_en),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    // Big-endian word: byte at addr is the high half.
    assign mem_data_out = {mem[mem_address[10:0]], mem[mem_address[10:0] + 11'd1]};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_wr_en && (mem_address > 16'h07FE)) bad_we_seen <= 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int idx_of(input logic [2:0] oh);
        for (int i = 0; i < 3; i++) if (oh[i]) return i;
        return 0;
    endfunction

    // First requesting index after 'last', wrapping modulo 3.
    function automatic logic [2:0] rr_expect(input logic [2:0] r, input int last);
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (last + k) % 3;
            if (r[c]) return 3'(1 << c);
        end
        return 3'b000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int i, input logic w, input logic [15:0] a, input logic [15:0] d);
        wr[i]             = w;
        addr[i*16 +: 16]  = a;
        wdata[i*16 +: 16] = d;
    endtask

    // One clock cycle: check the memory port for the inputs now applied,
    // advance the clock, update the bench memory, then check registered outputs.
    task automatic tick();
        logic [2:0]  p_req, p_wr, p_lock, e_done, e_err;
        logic [47:0] p_addr, p_wdata;
        logic        p_nrst, we, bad, exp_we;
        logic [10:0] wa, a1;
        logic [15:0] wd, a, exp_addr, exp_din;
        int          o;

        #1;
        if (m_valid) begin
            exp_addr = 16'h0;
            exp_din  = 16'h0;
            exp_we   = 1'b0;
            if (m_gnt != 3'b000) begin
                o        = idx_of(m_gnt);
                exp_addr = addr[o*16 +: 16];
                exp_din  = wdata[o*16 +: 16];
                exp_we   = wr[o] && (exp_addr <= 16'h07FE) && nrst;
            end
            chk("mem_address", 32'(mem_address), 32'(exp_addr));
            chk("mem_data_in", 32'(mem_data_in), 32'(exp_din));
            chk("mem_wr_en",   32'(mem_wr_en),   32'(exp_we));
        end
        p_req = req; p_wr = wr; p_lock = lock; p_addr = addr; p_wdata = wdata; p_nrst = nrst;
        we = mem_wr_en; wa = mem_address[10:0]; wd = mem_data_in;

        @(posedge clock);
        #1;
        if (we === 1'b1) begin
            mem[wa]         = wd[15:8];
            mem[wa + 11'd1] = wd[7:0];
        end

        e_done = 3'b000;
        e_err  = 3'b000;
        if (!p_nrst) begin
            m_gnt   = 3'b000;
            m_rdata = 16'h0;
            m_last  = 2;
        end else if (m_gnt != 3'b000) begin
            o   = idx_of(m_gnt);
            a   = p_addr[o*16 +: 16];
            bad = (a > 16'h07FE);
            a1  = a[10:0] + 11'd1;
            e_done  = m_gnt;
            e_err   = bad ? m_gnt : 3'b000;
            m_rdata = bad ? 16'h0 : {ref_mem[a[10:0]], ref_mem[a1]};
            $display("txn req%0d %s addr=%h wdata=%h rdata=%h err=%0d",
                     o, p_wr[o] ? "WR" : "RD", a, p_wdata[o*16 +: 16], m_rdata, bad);
            if (p_wr[o] && !bad) begin
                ref_mem[a[10:0]] = p_wdata[o*16+8 +: 8];
                ref_mem[a1]      = p_wdata[o*16 +: 8];
            end
            if (!(p_lock[o] && p_req[o])) begin
                m_gnt  = 3'b000;
                m_last = o;
            end
        end else begin
            m_gnt = rr_expect(p_req, m_last);
        end

        chk("gnt",   32'(gnt),   32'(m_gnt));
        chk("done",  32'(done),  32'(e_done));
        chk("err",   32'(err),   32'(e_err));
        chk("rdata", 32'(rdata), 32'(m_rdata));
    endtask

    // Single non-locked access by requester i; returns the completion outputs.
    task automatic access(input int i, input logic w, input logic [15:0] a, input logic [15:0] d,
                          output logic [15:0] rd, output logic [2:0] dn, output logic [2:0] er);
        int n;
        drive(i, w, a, d);
        req[i] = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (gnt[i] !== 1'b1 && n < 12);
        chk("access_grant", 32'(gnt[i]), 32'd1);
        req[i] = 1'b0;
        tick();
        rd = rdata;
        dn = done;
        er = err;
    endtask

    initial begin
        logic [15:0] rd, saved2;
        logic [2:0]  dn, er;
        logic [7:0]  saved;
        logic [2:0]  ord [4];
        int          wait_cnt [3];
        logic [15:0] ra;

        nrst = 1'b0; req = '0; wr = '0; lock = '0; addr = '0; wdata = '0;
        m_gnt = 3'b000; m_rdata = 16'h0; m_last = 2; m_valid = 1'b0;
        for (int j = 0; j < 2048; j++) mem[j] = 8'($urandom);
        mem[16'h10] = 8'h12;
        mem[16'h11] = 8'h34;
        for (int j = 0; j < 2048; j++) ref_mem[j] = mem[j];

        // Reset state
        tick();
        m_valid = 1'b1;
        tick();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        nrst = 1'b1;
        tick();

        // Single read with latency
        drive(0, 1'b0, 16'h0010, 16'h0000);
        req[0] = 1'b1;
        tick();
        chk("single_gnt_c1", 32'(gnt), 32'b001);
        req[0] = 1'b0;
        tick();
        chk("single_done_c2", 32'(done), 32'b001);
        chk("single_rdata_c2", 32'(rdata), 32'h1234);
        tick();

        // Contention from a fresh reset: 0,1,2,0 two cycles apart
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        drive(0, 1'b0, 16'h0020, 16'h0);
        drive(1, 1'b0, 16'h0040, 16'h0);
        drive(2, 1'b0, 16'h0060, 16'h0);
        req = 3'b111;
        ord[0] = 3'b001; ord[1] = 3'b010; ord[2] = 3'b100; ord[3] = 3'b001;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("contention_gnt", 32'(gnt), (k % 2 == 1) ? 32'(ord[(k-1)/2]) : 32'd0);
        end
        req = 3'b000;
        tick();
        tick();

        // Locked burst by requester 1 while requester 0 waits
        drive(1, 1'b1, 16'h0648, 16'hAAAA);
        drive(0, 1'b0, 16'h0200, 16'h0);
        lock[1] = 1'b1;
        req = 3'b011;
        tick();
        chk("burst_gnt_a", 32'(gnt), 32'b010);
        tick();
        chk("burst_gnt_b", 32'(gnt), 32'b010);
        drive(1, 1'b1, 16'h064A, 16'hBBBB);
        tick();
        chk("burst_gnt_c", 32'(gnt), 32'b010);
        chk("burst_done_b", 32'(done), 32'b010);
        drive(1, 1'b1, 16'h064C, 16'hCCCC);
        lock[1] = 1'b0;
        req[1]  = 1'b0;
        tick();
        chk("burst_release", 32'(gnt), 32'b000);
        tick();
        chk("burst_waiter_gnt", 32'(gnt), 32'b001);
        req[0] = 1'b0;
        tick();
        tick();
        access(2, 1'b0, 16'h0648, 16'h0, rd, dn, er);
        chk("burst_readback0", 32'(rd), 32'hAAAA);
        access(2, 1'b0, 16'h064A, 16'h0, rd, dn, er);
        chk("burst_readback1", 32'(rd), 32'hBBBB);
        access(2, 1'b0, 16'h064C, 16'h0, rd, dn, er);
        chk("burst_readback2", 32'(rd), 32'hCCCC);

        // Range boundaries: 0x7FE is the last legal word, 0x7FF is not
        access(0, 1'b1, 16'h07FE, 16'h9ABC, rd, dn, er);
        chk("edge_wr_err", 32'(er), 32'd0);
        access(0, 1'b0, 16'h07FE, 16'h0, rd, dn, er);
        chk("edge_readback", 32'(rd), 32'h9ABC);
        saved = mem[11'h7FF];
        access(2, 1'b1, 16'h07FF, 16'h5555, rd, dn, er);
        chk("oob_err", 32'(er), 32'b100);
        chk("oob_done", 32'(dn), 32'b100);
        chk("oob_rdata", 32'(rd), 32'd0);
        chk("oob_mem_kept", 32'(mem[11'h7FF]), 32'(saved));
        chk("oob_no_wr_en", 32'(bad_we_seen), 32'd0);

        // Reset during the second locked write
        saved2 = {mem[11'h102], mem[11'h103]};
        drive(1, 1'b1, 16'h0100, 16'h1111);
        lock[1] = 1'b1;
        req = 3'b010;
        tick();
        chk("rstburst_gnt_a", 32'(gnt), 32'b010);
        tick();
        chk("rstburst_gnt_b", 32'(gnt), 32'b010);
        drive(1, 1'b1, 16'h0102, 16'h2222);
        nrst = 1'b0;
        #1;
        chk("rstburst_wr_en_low", 32'(mem_wr_en), 32'd0);
        tick();
        chk("rstburst_gnt_zero", 32'(gnt), 32'd0);
        chk("rstburst_done_zero", 32'(done), 32'd0);
        chk("rstburst_err_zero", 32'(err), 32'd0);
        chk("rstburst_rdata_zero", 32'(rdata), 32'd0);
        nrst = 1'b1;
        lock = 3'b000;
        drive(0, 1'b0, 16'h0100, 16'h0);
        req = 3'b011;
        tick();
        chk("rstburst_next_gnt", 32'(gnt), 32'b001);
        req = 3'b000;
        tick();
        chk("rstburst_first_kept", 32'(rdata), 32'h1111);
        chk("rstburst_second_dropped", 32'({mem[11'h102], mem[11'h103]}), 32'(saved2));
        tick();

        // Randomized traffic, no locks
        for (int i = 0; i < 3; i++) wait_cnt[i] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                if (req[i] && gnt[i]) begin
                    chk("rand_grant_latency", 32'(wait_cnt[i] <= 12), 32'd1);
                    req[i] = 1'b0;
                    wait_cnt[i] = 0;
                end else if (req[i]) begin
                    wait_cnt[i]++;
                    if (wait_cnt[i] > 12) begin
                        chk("rand_starved", 32'(wait_cnt[i]), 32'd12);
                        req[i] = 1'b0;
                        wait_cnt[i] = 0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    case ($urandom_range(0, 9))
                        0:       ra = 16'($urandom_range(16'h07FF, 16'hFFFF));
                        1, 2, 3: ra = 16'h0300 + 16'($urandom_range(0, 15));
                        default: ra = 16'($urandom_range(0, 16'h07FE));
                    endcase
                    drive(i, 1'($urandom_range(0, 1)), ra, 16'($urandom));
                    req[i] = 1'b1;
                    wait_cnt[i] = 0;
                end
            end
        end
        req = 3'b000;
        tick();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NREQ, 3, number of requesters sharing the mem port.
REQ-002 Parameter AW, 16, address width (byte address).
REQ-003 Parameter DW, 16, data word width.
REQ-004 Parameter MEM_TOP, 'h7FF, highest legal byte address of mem.
REQ-005 The design SHALL use one clock and a synchronous, active-low reset.
REQ-006 Port clock, input, 1, sole clock, rising edge.
REQ-007 Port nrst, input, 1, synchronous active-low reset.
REQ-008 Port req, input, NREQ, per-requester access request, level.
REQ-009 Port wr, input, NREQ, per-requester write (1) / read (0).
REQ-010 Port lock, input, NREQ, per-requester burst hold.
REQ-011 Port addr, input, NREQ*AW, packed requester addresses, requester i at [i*AW +: AW].
REQ-012 Port wdata, input, NREQ*DW, packed requester write data.
REQ-013 Port gnt, output, NREQ, registered one-hot grant.
REQ-014 Port done, output, NREQ, one-cycle completion pulse.
REQ-015 Port err, output, NREQ, one-cycle out-of-range pulse, coincident with done.
REQ-016 Port rdata, output, DW, registered read data, shared.
REQ-017 Ports mem_address (AW), mem_wr_en (1), mem_data_in (DW) output; mem_data_out (DW) input; connect to mem.

Function
REQ-018 States: IDLE (gnt=0), ACCESS (gnt one-hot, owner o, exactly one mem access per cycle).
REQ-019 IDLE->ACCESS when any req high; winner = first set req scanning round-robin from last_owner+1 mod NREQ; gnt rises next cycle.
REQ-020 ACCESS->ACCESS same owner when lock[o] and req[o] both high in current cycle; no re-arbitration.
REQ-021 ACCESS->IDLE otherwise; mandatory dead cycle so requesters deassert req after seeing gnt.
REQ-022 last_owner updates to o on every ACCESS->IDLE transition.
REQ-023 In ACCESS: mem_address = addr[o], mem_data_in = wdata[o], mem_wr_en = wr[o] & ~range_err & nrst; combinational.
REQ-024 In IDLE: mem_address = 0, mem_data_in = 0, mem_wr_en = 0.
REQ-025 range_err = (addr[o] > MEM_TOP-1), covering the second byte at addr+1; odd addresses legal.
REQ-026 At end of each ACCESS cycle: rdata <= range_err ? 0 : mem_data_out (also on writes); done[o] and err[o]=range_err pulse in following cycle.
REQ-027 Read latency: req high cycle N -> gnt cycle N+1 -> done and rdata valid cycle N+2.
REQ-028 Locked burst: requester presents new addr/wr/wdata each gnt cycle; throughput one word per cycle; done pulses each cycle after each access.
REQ-029 Requester SHALL hold addr/wr/wdata stable from req rise until its gnt cycle; unchanged req without gnt is never dropped.
REQ-030 rdata holds last value when no done pulse.

Reset
REQ-031 nrst low at rising edge: state IDLE, gnt=0, done=0, err=0, rdata=0, last_owner=NREQ-1 (requester 0 wins first).
REQ-032 nrst low mid-ACCESS or mid-burst: mem_wr_en forced 0 same cycle; access abandoned; no done pulse.

Structure
REQ-033 Shared package holds NREQ, AW, DW, MEM_TOP, and state encoding constants.
REQ-034 Round-robin winner selection SHALL be sub-module rr_pick (inputs req vector and last_owner; output one-hot winner and valid).
REQ-035 No other sub-modules; mem instantiated outside, at bench/top level.

Verification
REQ-036 Single read: mem[0x10]=0x12, mem[0x11]=0x34; req[0], addr 0x10 -> gnt[0] cycle 1, done[0] and rdata=0x1234 cycle 2.
REQ-037 Contention: req=3'b111 held -> grants in order 0,1,2,0 each 2 cycles apart; no gnt overlap.
REQ-038 Locked burst: requester 1 lock=1, writes 0xAAAA,0xBBBB,0xCCCC to 0x648,0x64A,0x64C -> three consecutive gnt[1] cycles, req[0] waits until lock drops; readback matches.
REQ-039 Range: write addr 0x7FF from requester 2 -> err[2] and done[2] pulse, mem_wr_en never high, rdata=0, mem[0x7FF] unchanged.
REQ-040 Reset mid-burst: nrst low during second locked write -> mem_wr_en 0 that cycle, all outputs 0 next cycle, next arbitration grants requester 0.
